// File: rtl/fft_r4_pkg.sv
// Shared types and sizes for the 16-point radix-4 FFT input scheduler.
// The FFT frame length is fixed, so index widths are derived here once.
package fft_r4_pkg;

    localparam int DATA_W   = 32;
    localparam int N_POINTS = 16;
    localparam int GROUPS   = 4;
    localparam int IDX_W    = $clog2(N_POINTS);
    localparam int CPLX_W   = 2 * DATA_W;

    // Real part sits in the upper half of the packed word.
    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

endpackage

// File: rtl/fft_pingpong_buf.sv
// Two-bank frame store: the upstream fills one bank while the other is burst out.
// Bank ownership is tracked with one full flag per bank plus write/read bank pointers.
module fft_pingpong_buf
    import fft_r4_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [CPLX_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_at_last,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic              rd_free,
    output logic              rd_full,
    output logic              rd_next_full,
    output logic [CPLX_W-1:0] rd_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    cplx_t            mem [0:2*N_POINTS-1];
    cplx_t            rd_data_reg;
    logic [IDX_W-1:0] widx_reg;
    logic             wbank_reg;
    logic             rbank_reg;
    logic [1:0]       full_reg;
    logic [1:0]       full_next;
    logic             wr_close;

    assign wr_at_last   = (widx_reg == LAST_IDX);
    assign wr_close     = wr_en && wr_at_last;
    assign wr_ready     = ~full_reg[wbank_reg];
    assign rd_full      = full_reg[rbank_reg];
    assign rd_next_full = full_reg[~rbank_reg];
    assign rd_data      = rd_data_reg;

    // Freeing the read bank wins over closing a frame; they never hit the same bank anyway.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign full_next[gi] = (rd_free && (rbank_reg == 1'(gi))) ? 1'b0 :
                                   (wr_close && (wbank_reg == 1'(gi))) ? 1'b1 :
                                   full_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            widx_reg  <= '0;
            wbank_reg <= 1'b0;
            rbank_reg <= 1'b0;
            full_reg  <= '0;
        end else begin
            full_reg <= full_next;
            if (wr_en) begin
                widx_reg <= wr_close ? '0 : widx_reg + 1'b1;
                if (wr_close) begin
                    wbank_reg <= ~wbank_reg;
                end
            end
            if (rd_free) begin
                rbank_reg <= ~rbank_reg;
            end
        end
    end

    // Storage has no reset so it maps onto block RAM with a registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wbank_reg, widx_reg}] <= wr_data;
        end
        rd_data_reg <= mem[{rbank_reg, rd_idx}];
    end

endmodule

// File: rtl/fft_r4_16p_frame_sched.sv
// Frame scheduler in front of the 16-point radix-4 FFT: buffers gappy input into
// ping-pong banks, bursts complete frames gaplessly and tracks FFT output groups.
module fft_r4_16p_frame_sched #(
    parameter int DATA_W      = 32,
    parameter int N_POINTS    = 16,
    parameter int FFT_LATENCY = 12,
    parameter int FRAME_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATA_W-1:0]  s_real,
    input  logic [DATA_W-1:0]  s_im,
    input  logic               s_last,
    output logic [DATA_W-1:0]  fft_in_real,
    output logic [DATA_W-1:0]  fft_in_im,
    output logic               fft_in_valid,
    output logic               out_valid,
    output logic [1:0]         out_group,
    output logic [FRAME_W-1:0] out_frame,
    output logic               frame_err,
    output logic               busy
);
    import fft_r4_pkg::*;

    localparam int               PIPE_W   = FFT_LATENCY - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    sched_state_t       state_reg, state_next;
    logic [IDX_W-1:0]   ridx_reg, ridx_next;
    logic               rd_go;
    logic               rd_free;
    logic               rd_full;
    logic               rd_next_full;
    logic               wr_en;
    logic               wr_ready;
    logic               wr_at_last;
    cplx_t              wr_word;
    cplx_t              rd_word;
    logic [CPLX_W-1:0]  rd_data;
    logic               fft_valid_reg;
    logic               start_reg;
    logic [PIPE_W-1:0]  pipe_reg;
    logic [PIPE_W-1:0]  pipe_next;
    logic               out_valid_reg;
    logic [1:0]         out_group_reg;
    logic [FRAME_W-1:0] out_frame_reg;
    logic               frame_err_reg;

    assign s_ready    = ~reset & wr_ready;
    assign wr_en      = s_valid & s_ready;
    assign wr_word.re = s_real;
    assign wr_word.im = s_im;
    assign rd_word    = rd_data;

    fft_pingpong_buf u_pingpong (
        .clk          (clk),
        .srst         (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_word),
        .wr_ready     (wr_ready),
        .wr_at_last   (wr_at_last),
        .rd_idx       (ridx_reg),
        .rd_free      (rd_free),
        .rd_full      (rd_full),
        .rd_next_full (rd_next_full),
        .rd_data      (rd_data)
    );

    // ridx_reg is the address being read this cycle; the sample appears on fft_in_* next cycle.
    always_comb begin
        state_next = state_reg;
        ridx_next  = ridx_reg;
        rd_free    = 1'b0;
        rd_go      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rd_full) begin
                    rd_go      = 1'b1;
                    state_next = BURST;
                    ridx_next  = IDX_W'(1);
                end
            end
            BURST: begin
                rd_go = 1'b1;
                if (ridx_reg == LAST_IDX) begin
                    rd_free    = 1'b1;
                    ridx_next  = '0;
                    state_next = rd_next_full ? BURST : IDLE;
                end else begin
                    ridx_next = ridx_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ridx_reg      <= '0;
            fft_valid_reg <= 1'b0;
            start_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ridx_reg      <= ridx_next;
            fft_valid_reg <= rd_go;
            start_reg     <= rd_go && (ridx_reg == '0);
            if (wr_en && (s_last != wr_at_last)) begin
                frame_err_reg <= 1'b1;
            end
        end
    end

    // Start marker travels alongside the FFT pipeline; the output register adds the last clock.
    assign pipe_next[0] = start_reg;
    genvar gi;
    generate
        for (gi = 1; gi < PIPE_W; gi++) begin : g_pipe
            assign pipe_next[gi] = pipe_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_group_reg <= '0;
            out_frame_reg <= '0;
        end else begin
            pipe_reg <= pipe_next;
            if (pipe_reg[PIPE_W-1]) begin
                out_valid_reg <= 1'b1;
                out_group_reg <= '0;
            end else if (out_valid_reg) begin
                if (out_group_reg == 2'(GROUPS - 1)) begin
                    out_valid_reg <= 1'b0;
                    out_group_reg <= '0;
                    out_frame_reg <= out_frame_reg + 1'b1;
                end else begin
                    out_group_reg <= out_group_reg + 1'b1;
                end
            end
        end
    end

    assign fft_in_valid = fft_valid_reg;
    assign fft_in_real  = fft_valid_reg ? rd_word.re : '0;
    assign fft_in_im    = fft_valid_reg ? rd_word.im : '0;
    assign out_valid    = out_valid_reg;
    assign out_group    = out_group_reg;
    assign out_frame    = out_frame_reg;
    assign frame_err    = frame_err_reg;
    assign busy         = rd_full | rd_next_full | (state_reg != IDLE) | fft_valid_reg
                        | start_reg | (|pipe_reg) | out_valid_reg;

endmodule

// File: tb/tb_fft_r4_16p_frame_sched.sv
// Randomised bench for the FFT frame scheduler; a frame-level timing model predicts
// every output each cycle from accept times and the burst/latency rules.
module tb_fft_r4_16p_frame_sched;

    localparam int DW   = 32;
    localparam int FW   = 8;
    localparam int MAXF = 320;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_real;
    logic [DW-1:0] s_im;
    logic          s_last;
    logic [DW-1:0] fft_in_real;
    logic [DW-1:0] fft_in_im;
    logic          fft_in_valid;
    logic          out_valid;
    logic [1:0]    out_group;
    logic [FW-1:0] out_frame;
    logic          frame_err;
    logic          busy;

    always #5 clk = ~clk;

    fft_r4_16p_frame_sched #(
        .DATA_W      (DW),
        .N_POINTS    (16),
        .FFT_LATENCY (12),
        .FRAME_W     (FW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_real       (s_real),
        .s_im         (s_im),
        .s_last       (s_last),
        .fft_in_real  (fft_in_real),
        .fft_in_im    (fft_in_im),
        .fft_in_valid (fft_in_valid),
        .out_valid    (out_valid),
        .out_group    (out_group),
        .out_frame    (out_frame),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference: per frame, its samples, accept cycle of sample 15 and burst start.
    logic [63:0] fsamp [0:MAXF-1][0:15];
    logic [63:0] cur   [0:15];
    int          a15   [0:MAXF-1];
    int          sst   [0:MAXF-1];
    int          acc_at[0:63];
    int          nf = 0;
    int          widx_m = 0;
    logic        err_m = 1'b0;
    int          cyc = 0;
    bit          model_on = 1'b0;
    int          acc_cnt = 0;
    int          first_valid_cyc = -1;

    always @(negedge clk) begin : model
        int   lo, held, done, eg;
        logic ev, eov, eb;
        logic [63:0] ed;
        if (model_on) begin
            lo = (nf > 4) ? nf - 4 : 0;
            held = 0; done = lo; eg = 0;
            ev = 1'b0; eov = 1'b0; eb = 1'b0; ed = '0;
            for (int f = lo; f < nf; f++) begin
                if (a15[f] < cyc && cyc < sst[f] + 15) held++;
                if (a15[f] < cyc && cyc <= sst[f] + 15) eb = 1'b1;
                if (cyc >= sst[f] && cyc < sst[f] + 16) begin
                    ev = 1'b1;
                    ed = fsamp[f][cyc - sst[f]];
                end
                if (cyc >= sst[f] + 12 && cyc <= sst[f] + 15) begin
                    eov = 1'b1;
                    eg  = cyc - sst[f] - 12;
                end
                if (sst[f] + 15 < cyc) done++;
            end
            check_eq("s_ready", s_ready, !reset && (held < 2));
            check_eq("fft_in_valid", fft_in_valid, ev);
            check_eq("fft_in_data", {fft_in_real, fft_in_im}, ed);
            check_eq("out_valid", out_valid, eov);
            if (eov) check_eq("out_group", out_group, 64'(eg));
            check_eq("out_frame", out_frame, 64'(done % 256));
            check_eq("frame_err", frame_err, err_m);
            check_eq("busy", busy, eb);
            if (fft_in_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (reset) begin
            model_on = 1'b1;
            nf = 0; widx_m = 0; err_m = 1'b0; acc_cnt = 0; first_valid_cyc = -1;
        end else if (model_on && s_valid && s_ready) begin
            if (acc_cnt < 64) acc_at[acc_cnt] = cyc;
            acc_cnt++;
            cur[widx_m] = {s_real, s_im};
            if (s_last != (widx_m == 15)) err_m = 1'b1;
            if (widx_m == 15) begin
                if (nf < MAXF) begin
                    for (int k = 0; k < 16; k++) fsamp[nf][k] = cur[k];
                    a15[nf] = cyc;
                    sst[nf] = (nf > 0 && sst[nf-1] + 16 > cyc + 2) ? sst[nf-1] + 16 : cyc + 2;
                    nf++;
                end
                widx_m = 0;
            end else begin
                widx_m++;
            end
        end
        cyc++;
    end

    function automatic logic [31:0] pat(input int i);
        return (i == 0) ? 32'd0 : 32'((i - 1) % 3 + 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        s_valid = 1'b0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic send(input logic [31:0] re, input logic [31:0] im, input logic last, input int gap);
        bit acc;
        int wd;
        repeat (gap) begin
            s_valid = 1'b0;
            step();
        end
        s_valid = 1'b1; s_real = re; s_im = im; s_last = last;
        acc = 1'b0; wd = 0;
        while (!acc && wd < 200) begin
            @(negedge clk);
            acc = s_ready;
            step();
            wd++;
        end
        if (!acc) check_eq("ready_timeout", 64'(acc), 64'd1);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    // datamode 0: counting pattern, 1: random; gapmode 0: none, 1: alternate, 2: random
    task automatic send_frame(input int datamode, input int gapmode, input int bad_at);
        logic [31:0] re, im;
        int gap;
        for (int i = 0; i < 16; i++) begin
            re = (datamode == 0) ? pat(i) : $urandom;
            im = (datamode == 0) ? pat(i) : $urandom;
            gap = (gapmode == 1 && i > 0) ? 1 : (gapmode == 2) ? int'($urandom_range(0, 3)) : 0;
            send(re, im, (bad_at >= 0) ? (i == bad_at) : (i == 15), gap);
        end
    endtask

    initial begin
        int k, t;
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_real = '0; s_im = '0;
        do_reset(3);

        // gapless counting frame: latency and ordering
        send_frame(0, 0, -1);
        repeat (40) step();
        check_eq("first_valid_latency", 64'(first_valid_cyc), 64'(a15[0] + 2));

        // alternating valid, two frames
        do_reset(1);
        send_frame(1, 1, -1);
        send_frame(1, 1, -1);
        repeat (40) step();

        // three frames back to back; sample 32 accepted as bank 0 frees
        do_reset(1);
        for (int f = 0; f < 3; f++) send_frame(1, 0, -1);
        repeat (40) step();
        check_eq("s32_accept_cycle", 64'(acc_at[32]), 64'(sst[0] + 15));

        // misplaced s_last: sticky error, frame still closes on count
        do_reset(1);
        send_frame(1, 2, 7);
        repeat (10) step();
        check_eq("frame_err_set", frame_err, 1'b1);
        send_frame(1, 2, -1);
        repeat (40) step();
        check_eq("frame_err_sticky", frame_err, 1'b1);

        // reset in the middle of a burst
        do_reset(1);
        send_frame(1, 0, -1);
        k = 0; t = 0;
        while (k < 7 && t < 100) begin
            @(negedge clk);
            if (fft_in_valid) k++;
            t++;
        end
        check_eq("burst_before_reset", 64'(k), 64'd7);
        step();
        do_reset(1);
        repeat (30) step();
        send_frame(0, 0, -1);
        repeat (30) step();

        // random data and gaps
        do_reset(1);
        for (int f = 0; f < 8; f++) send_frame(1, 2, ($urandom_range(0, 7) == 0) ? 3 : -1);
        repeat (40) step();

        // long gapless run so out_frame wraps
        do_reset(1);
        for (int f = 0; f < 260; f++) send_frame(1, 0, -1);
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
